// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control
//  Description : RV32I ALU decode stage. Maps opcode bits {6,5,4,2}, funct3
//                and instruction bit 30 to a 5-bit ALU operation code.
//                The output is registered (one cycle latency) with enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_control (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enb,
    input  logic [3:0] iv_Alu_opcode,
    input  logic       i_Bit_30,
    input  logic [2:0] iv_funct3,
    output logic [4:0] ov_AluOp
);

    // ALU operation encodings
    localparam logic [4:0] c_ADD     = 5'b00000;
    localparam logic [4:0] c_SUB     = 5'b00001;
    localparam logic [4:0] c_SLL     = 5'b00010;
    localparam logic [4:0] c_SLT     = 5'b00011;
    localparam logic [4:0] c_SLTU    = 5'b00100;
    localparam logic [4:0] c_XOR     = 5'b00101;
    localparam logic [4:0] c_SRL     = 5'b00110;
    localparam logic [4:0] c_SRA     = 5'b00111;
    localparam logic [4:0] c_OR      = 5'b01000;
    localparam logic [4:0] c_AND     = 5'b01001;
    localparam logic [4:0] c_PASSB   = 5'b01010;
    localparam logic [4:0] c_BEQ     = 5'b01011;
    localparam logic [4:0] c_BNE     = 5'b01100;
    localparam logic [4:0] c_BLT     = 5'b01101;
    localparam logic [4:0] c_BGE     = 5'b01110;
    localparam logic [4:0] c_BLTU    = 5'b01111;
    localparam logic [4:0] c_BGEU    = 5'b10000;
    localparam logic [4:0] c_INVALID = 5'b11111;

    // Compressed opcode values (instruction bits {6,5,4,2})
    localparam logic [3:0] c_OPC_LOAD   = 4'b0000;
    localparam logic [3:0] c_OPC_STORE  = 4'b0100;
    localparam logic [3:0] c_OPC_OPIMM  = 4'b0010;
    localparam logic [3:0] c_OPC_OP     = 4'b0110;
    localparam logic [3:0] c_OPC_BRANCH = 4'b1100;
    localparam logic [3:0] c_OPC_LUI    = 4'b0111;
    localparam logic [3:0] c_OPC_AUIPC  = 4'b0011;
    localparam logic [3:0] c_OPC_JAL    = 4'b1101;

    logic [4:0] alu_op_d;
    logic [4:0] alu_op_q;

    // Decode: selection keys only on opcode and funct3; bit 30 is read solely
    // in the arms where it distinguishes two operations, so an unknown bit 30
    // elsewhere never reaches the register.
    always_comb begin
        alu_op_d = c_INVALID;
        case (iv_Alu_opcode)
            c_OPC_LOAD,
            c_OPC_STORE,
            c_OPC_AUIPC,
            c_OPC_JAL: alu_op_d = c_ADD;

            c_OPC_LUI: alu_op_d = c_PASSB;

            c_OPC_OPIMM: begin
                case (iv_funct3)
                    3'b000:  alu_op_d = c_ADD;
                    3'b001:  alu_op_d = c_SLL;
                    3'b010:  alu_op_d = c_SLT;
                    3'b011:  alu_op_d = c_SLTU;
                    3'b100:  alu_op_d = c_XOR;
                    3'b101:  alu_op_d = i_Bit_30 ? c_SRA : c_SRL;
                    3'b110:  alu_op_d = c_OR;
                    3'b111:  alu_op_d = c_AND;
                    default: alu_op_d = c_INVALID;
                endcase
            end

            c_OPC_OP: begin
                case (iv_funct3)
                    3'b000:  alu_op_d = i_Bit_30 ? c_SUB : c_ADD;
                    3'b001:  alu_op_d = c_SLL;
                    3'b010:  alu_op_d = c_SLT;
                    3'b011:  alu_op_d = c_SLTU;
                    3'b100:  alu_op_d = c_XOR;
                    3'b101:  alu_op_d = i_Bit_30 ? c_SRA : c_SRL;
                    3'b110:  alu_op_d = c_OR;
                    3'b111:  alu_op_d = c_AND;
                    default: alu_op_d = c_INVALID;
                endcase
            end

            c_OPC_BRANCH: begin
                case (iv_funct3)
                    3'b000:  alu_op_d = c_BEQ;
                    3'b001:  alu_op_d = c_BNE;
                    3'b100:  alu_op_d = c_BLT;
                    3'b101:  alu_op_d = c_BGE;
                    3'b110:  alu_op_d = c_BLTU;
                    3'b111:  alu_op_d = c_BGEU;
                    default: alu_op_d = c_INVALID;
                endcase
            end

            default: alu_op_d = c_INVALID;
        endcase
    end

    // Output register: reset to ADD, load decode when enabled, otherwise hold
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            alu_op_q <= c_ADD;
        end else if (i_Enb) begin
            alu_op_q <= alu_op_d;
        end
    end

    assign ov_AluOp = alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control
//  Description : Self-checking bench for alu_control. Directed sequences plus
//                randomized cycles compared against a table-driven model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Enb;
    logic [3:0] iv_Alu_opcode;
    logic       i_Bit_30;
    logic [2:0] iv_funct3;
    logic [4:0] ov_AluOp;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q;

    alu_control u_dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Enb         (i_Enb),
        .iv_Alu_opcode (iv_Alu_opcode),
        .i_Bit_30      (i_Bit_30),
        .iv_funct3     (iv_funct3),
        .ov_AluOp      (ov_AluOp)
    );

    always #5 i_Clk = ~i_Clk;

    // Compare one observed value against its expectation
    task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference decode built from lookup tables indexed by funct3.
    // Arithmetic table holds the bit30=0 operation; SUB and SRA are the
    // numerically next code after ADD and SRL respectively.
    function automatic logic [4:0] ref_decode(input logic [3:0] opc, input logic [2:0] f3, input logic b30);
        logic [4:0] arith [8];
        logic [4:0] brn   [8];
        arith = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        brn   = '{5'd11, 5'd12, 5'd31, 5'd31, 5'd13, 5'd14, 5'd15, 5'd16};
        if (opc == 4'b0000 || opc == 4'b0100 || opc == 4'b0011 || opc == 4'b1101)
            return 5'd0;
        if (opc == 4'b0111)
            return 5'd10;
        if (opc == 4'b0010)
            return arith[f3] + ((f3 == 3'd5 && b30) ? 5'd1 : 5'd0);
        if (opc == 4'b0110)
            return arith[f3] + (((f3 == 3'd5 || f3 == 3'd0) && b30) ? 5'd1 : 5'd0);
        if (opc == 4'b1100)
            return brn[f3];
        return 5'd31;
    endfunction

    // Apply inputs, clock one edge, advance the model and check the output
    task automatic step(input string tag, input logic rst, input logic enb,
                        input logic [3:0] opc, input logic [2:0] f3, input logic b30);
        i_Rst         = rst;
        i_Enb         = enb;
        iv_Alu_opcode = opc;
        iv_funct3     = f3;
        i_Bit_30      = b30;
        @(posedge i_Clk);
        if (rst)      exp_q = 5'd0;
        else if (enb) exp_q = ref_decode(opc, f3, b30);
        #1;
        check_eq(tag, ov_AluOp, exp_q);
    endtask

    initial begin
        logic [2:0] ls_f3 [5];
        logic [2:0] imm_f3 [6];
        logic [4:0] imm_exp [6];
        logic [4:0] br_exp [6];
        logic [2:0] br_f3 [6];
        ls_f3   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        imm_f3  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        imm_exp = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01001};
        br_f3   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        br_exp  = '{5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000};
        exp_q   = 5'd0;

        i_Rst = 1'b1; i_Enb = 1'b1; iv_Alu_opcode = 4'b0110; iv_funct3 = 3'b111; i_Bit_30 = 1'b0;

        // Reset holds ADD, then AND appears after release
        step("reset0", 1'b1, 1'b1, 4'b0110, 3'b111, 1'b0);
        step("reset1", 1'b1, 1'b1, 4'b0110, 3'b111, 1'b0);
        check_eq("reset_const", ov_AluOp, 5'b00000);
        step("post_reset_and", 1'b0, 1'b1, 4'b0110, 3'b111, 1'b0);
        check_eq("post_reset_and_const", ov_AluOp, 5'b01001);

        // LOAD / STORE always ADD regardless of bit 30
        foreach (ls_f3[i]) begin
            step("load", 1'b0, 1'b1, 4'b0000, ls_f3[i], 1'($urandom));
            check_eq("load_const", ov_AluOp, 5'b00000);
            step("store", 1'b0, 1'b1, 4'b0100, ls_f3[i], 1'($urandom));
            check_eq("store_const", ov_AluOp, 5'b00000);
        end

        // OP-IMM sweep
        foreach (imm_f3[i]) begin
            step("opimm", 1'b0, 1'b1, 4'b0010, imm_f3[i], 1'($urandom));
            check_eq("opimm_const", ov_AluOp, imm_exp[i]);
        end
        step("opimm_sll", 1'b0, 1'b1, 4'b0010, 3'd1, 1'b0);
        check_eq("opimm_sll_const", ov_AluOp, 5'b00010);
        step("opimm_srl", 1'b0, 1'b1, 4'b0010, 3'd5, 1'b0);
        check_eq("opimm_srl_const", ov_AluOp, 5'b00110);
        step("opimm_sra", 1'b0, 1'b1, 4'b0010, 3'd5, 1'b1);
        check_eq("opimm_sra_const", ov_AluOp, 5'b00111);

        // R-type sweep, both values of bit 30
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 2; b++) begin
                step("rtype", 1'b0, 1'b1, 4'b0110, 3'(f), 1'(b));
            end
        end
        step("r_sub", 1'b0, 1'b1, 4'b0110, 3'd0, 1'b1);
        check_eq("r_sub_const", ov_AluOp, 5'b00001);

        // Enable hold: SUB stays while inputs change to XOR, then XOR loads
        step("hold_load_sub", 1'b0, 1'b1, 4'b0110, 3'd0, 1'b1);
        step("hold_a", 1'b0, 1'b0, 4'b0110, 3'd4, 1'b0);
        check_eq("hold_a_const", ov_AluOp, 5'b00001);
        step("hold_b", 1'b0, 1'b0, 4'b0110, 3'd4, 1'b0);
        step("hold_release", 1'b0, 1'b1, 4'b0110, 3'd4, 1'b0);
        check_eq("hold_release_const", ov_AluOp, 5'b00101);

        // Branches and miscellaneous opcodes
        foreach (br_f3[i]) begin
            step("branch", 1'b0, 1'b1, 4'b1100, br_f3[i], 1'($urandom));
            check_eq("branch_const", ov_AluOp, br_exp[i]);
        end
        step("branch_010", 1'b0, 1'b1, 4'b1100, 3'd2, 1'b0);
        check_eq("branch_010_const", ov_AluOp, 5'b11111);
        step("branch_011", 1'b0, 1'b1, 4'b1100, 3'd3, 1'b1);
        step("lui", 1'b0, 1'b1, 4'b0111, 3'($urandom), 1'($urandom));
        check_eq("lui_const", ov_AluOp, 5'b01010);
        step("auipc", 1'b0, 1'b1, 4'b0011, 3'($urandom), 1'($urandom));
        check_eq("auipc_const", ov_AluOp, 5'b00000);
        step("jal", 1'b0, 1'b1, 4'b1101, 3'($urandom), 1'($urandom));
        check_eq("jal_const", ov_AluOp, 5'b00000);
        step("opc_1111", 1'b0, 1'b1, 4'b1111, 3'($urandom), 1'($urandom));
        check_eq("opc_1111_const", ov_AluOp, 5'b11111);

        // Reset overrides enable mid-stream
        step("reset_over_enb", 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0);
        check_eq("reset_over_enb_const", ov_AluOp, 5'b00000);

        // Randomized cycles: all opcodes, sporadic enable drops and resets
        for (int n = 0; n < 400; n++) begin
            step("random",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
